// File: rtl/ysyx_22040759_pipe_ctrl_if.sv
// Hazard/event inputs and per-stage control outputs of the pipeline sequencer.
// The core-side logic drives the master modport; the sequencer uses slave.
interface ysyx_22040759_pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    // hazard and bus-wait sources
    logic             ld_use_hzd;
    logic             if_busy;
    logic             mem_busy;
    logic             mdu_start;
    logic             mdu_done;
    logic             redirect;
    logic             trap;

    // per-stage controls and performance counters
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             mdu_kill;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ld_use_hzd, if_busy, mem_busy, mdu_start, mdu_done, redirect, trap,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mdu_kill,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  ld_use_hzd, if_busy, mem_busy, mdu_start, mdu_done, redirect, trap,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        output if_id_flush, id_ex_flush, ex_mem_flush, mdu_kill,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ysyx_22040759_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage core: resolves hazards, bus waits,
// MUL/DIV stalls, redirects and traps into stage enables, with perf counters.
module ysyx_22040759_pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_22040759_pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_MDU_WAIT   = 2'd1,
        S_REDIR_PEND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mdu_kill;

    // NOTE: every output gets its default before the priority chain, so no
    // path through the block leaves a signal unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        mem_wb_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_kill     = 1'b0;

        if (rst) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            mem_wb_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = S_RUN;
        end else if (bus.mem_busy) begin
            // LSU wait freezes the whole pipe; pending events are held by their sources
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if (bus.trap) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            mdu_kill     = (state_q == S_MDU_WAIT);
            state_d      = bus.if_busy ? S_REDIR_PEND : S_RUN;
        end else begin
            unique case (state_q)
                S_MDU_WAIT: begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                    id_ex_we = 1'b0;
                    if (bus.mdu_done) begin
                        state_d = S_RUN;
                    end else begin
                        ex_mem_flush = 1'b1;
                    end
                end
                S_REDIR_PEND: begin
                    if (bus.redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = bus.if_busy ? S_REDIR_PEND : S_RUN;
                    end else if (bus.if_busy) begin
                        // the outstanding fetch belongs to the old path: drop it
                        pc_we       = 1'b0;
                        if_id_flush = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_d     = bus.if_busy ? S_REDIR_PEND : S_RUN;
                    end else if (bus.mdu_start) begin
                        pc_we        = 1'b0;
                        if_id_we     = 1'b0;
                        id_ex_we     = 1'b0;
                        ex_mem_flush = 1'b1;
                        state_d      = S_MDU_WAIT;
                    end else if (bus.ld_use_hzd || bus.if_busy) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    // Saturating performance counters; the reset cycle itself is not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rst) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_we && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if ((if_id_flush || id_ex_flush || ex_mem_flush) && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: reset is synchronous and already folded into the _d terms above,
    // so the registers are plain non-blocking D flops.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign bus.pc_we        = pc_we;
    assign bus.if_id_we     = if_id_we;
    assign bus.id_ex_we     = id_ex_we;
    assign bus.ex_mem_we    = ex_mem_we;
    assign bus.mem_wb_we    = mem_wb_we;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_flush = ex_mem_flush;
    assign bus.mdu_kill     = mdu_kill;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_22040759_pipe_ctrl.sv
// Scoreboard bench for the pipeline sequencer: a driver predicts each cycle's
// controls from a pending-context model, a monitor compares on the falling edge.
module tb_ysyx_22040759_pipe_ctrl;

    localparam int CNT_W = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mdu_kill;
    } ctrl_t;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22040759_pipe_ctrl_if #(.CNT_W(CNT_W)) pif ();

    ysyx_22040759_pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference context: is a MUL/DIV in flight, is a stale fetch outstanding.
    bit          m_mdu  = 1'b0;
    bit          m_pend = 1'b0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    task automatic step(input bit r, input bit ld, input bit ifb, input bit mb,
                        input bit ms, input bit md, input bit rd, input bit tr);
        ctrl_t e;
        exp_t  x;
        @(posedge clk);
        #1;
        rst            = r;
        pif.ld_use_hzd = ld;
        pif.if_busy    = ifb;
        pif.mem_busy   = mb;
        pif.mdu_start  = ms;
        pif.mdu_done   = md;
        pif.redirect   = rd;
        pif.trap       = tr;

        e = ctrl_t'(9'b11111_0000);
        if (r) begin
            e = ctrl_t'(9'b00000_1110);
            m_mdu  = 1'b0;
            m_pend = 1'b0;
        end else if (mb) begin
            e = ctrl_t'(9'b00000_0000);
        end else if (tr) begin
            e.if_id_flush  = 1'b1;
            e.id_ex_flush  = 1'b1;
            e.ex_mem_flush = 1'b1;
            e.mdu_kill     = m_mdu;
            m_mdu  = 1'b0;
            m_pend = ifb;
        end else if (m_mdu) begin
            e.pc_we    = 1'b0;
            e.if_id_we = 1'b0;
            e.id_ex_we = 1'b0;
            if (md) m_mdu = 1'b0;
            else    e.ex_mem_flush = 1'b1;
        end else if (rd) begin
            e.if_id_flush = 1'b1;
            e.id_ex_flush = 1'b1;
            m_pend = ifb;
        end else if (m_pend) begin
            if (ifb) begin
                e.pc_we       = 1'b0;
                e.if_id_flush = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
        end else if (ms) begin
            e.pc_we        = 1'b0;
            e.if_id_we     = 1'b0;
            e.id_ex_we     = 1'b0;
            e.ex_mem_flush = 1'b1;
            m_mdu = 1'b1;
        end else if (ld || ifb) begin
            e.pc_we       = 1'b0;
            e.if_id_we    = 1'b0;
            e.id_ex_flush = 1'b1;
        end

        x.ctrl  = e;
        x.stall = m_stall[CNT_W-1:0];
        x.flush = m_flush[CNT_W-1:0];
        exp_q.push_back(x);

        if (r) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e.pc_we && m_stall < CNT_MAX) m_stall++;
            if ((e.if_id_flush || e.id_ex_flush || e.ex_mem_flush) && m_flush < CNT_MAX) m_flush++;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a full control word.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  x;
            ctrl_t a;
            x = exp_q.pop_front();
            a = {pif.pc_we, pif.if_id_we, pif.id_ex_we, pif.ex_mem_we, pif.mem_wb_we,
                 pif.if_id_flush, pif.id_ex_flush, pif.ex_mem_flush, pif.mdu_kill};
            n_checks++;
            if (a !== x.ctrl) begin
                n_errors++;
                $display("FAIL ctrl t=%0t got=%b exp=%b (we5,flush3,kill)", $time, a, x.ctrl);
            end
            n_checks++;
            if (pif.stall_cnt !== x.stall) begin
                n_errors++;
                $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, pif.stall_cnt, x.stall);
            end
            n_checks++;
            if (pif.flush_cnt !== x.flush) begin
                n_errors++;
                $display("FAIL flush_cnt t=%0t got=%0d exp=%0d", $time, pif.flush_cnt, x.flush);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        pif.ld_use_hzd = 1'b0;
        pif.if_busy    = 1'b0;
        pif.mem_busy   = 1'b0;
        pif.mdu_start  = 1'b0;
        pif.mdu_done   = 1'b0;
        pif.redirect   = 1'b0;
        pif.trap       = 1'b0;

        // reset held two cycles, then release
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // single-cycle load-use bubble
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle();

        // MUL/DIV: start, four waits, done; the start-cycle done is ignored
        step(0, 0, 0, 0, 1, 1, 0, 0);
        repeat (4) idle();
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle();

        // redirect with a stale fetch outstanding for three more cycles
        step(0, 0, 1, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0, 0, 0);
        idle();
        idle();

        // redirect beats mdu_start; redirect accepted again while pending
        step(0, 0, 1, 0, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // trap during MDU_WAIT kills the op; later done has no effect
        step(0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle();

        // trap with fetch outstanding enters the pending-discard context
        step(0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // mem_busy freezes everything while trap is held, trap acts afterwards
        repeat (4) step(0, 0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 99) < 1),
                 ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 35),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 4));
        end

        // counter saturation: long LSU wait, then a long stream of traps
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (CNT_MAX + 40) step(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (CNT_MAX + 40) step(0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected entries never compared", exp_q.size());
        end
        #1;
        n_checks++;
        if (pif.stall_cnt !== CNT_W'(CNT_MAX)) begin
            n_errors++;
            $display("FAIL stall_sat got=%0d exp=%0d", pif.stall_cnt, CNT_MAX);
        end
        n_checks++;
        if (pif.flush_cnt !== CNT_W'(CNT_MAX)) begin
            n_errors++;
            $display("FAIL flush_sat got=%0d exp=%0d", pif.flush_cnt, CNT_MAX);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
